// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage upstream of the execute core.
//
// Reads a byte-wide instruction memory one byte per request (one request
// outstanding, variable latency), assembles little-endian 32-bit RV32
// instructions and presents them downstream on a valid/ready handshake.
// Execute may redirect the fetch PC at any time (taken branch, JAL).
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   : a misaligned fetch PC parks the stage in FAULT until redirect
//   undefined : pc[1:0] is cleared on every load and fault is tied low
//
// Ports:
//   clk            in   clock, all logic on posedge
//   rst            in   synchronous active-high reset
//   mem_req        out  one-cycle byte read request
//   mem_addr       out  byte address (low ADDR_W bits of pc+idx)
//   mem_rvalid     in   read data valid, one per request
//   mem_rdata      in   read byte
//   instr_valid    out  instr_out/pc_out hold a complete instruction
//   instr_ready    in   downstream accepts
//   instr_out      out  assembled instruction {b3,b2,b1,b0}
//   pc_out         out  address of instr_out
//   redirect_valid in   load redirect_pc as the next fetch PC
//   redirect_pc    in   redirect target
//   fault          out  misaligned-PC fault
//
// States:
//   S_REQ   | issue a byte request for pc+idx
//   S_WAIT  | waiting for the byte response, write it into lane idx
//   S_HOLD  | complete instruction presented, waiting for transfer
//   S_DRAIN | redirect arrived with a response outstanding; drop that byte
//   S_FAULT | misaligned pc, stalled until redirect

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] instr_q, instr_d;
  logic        req_misaligned;

  // Every PC load goes through here so the alignment policy lives in one place.
  function automatic logic [31:0] load_pc(input logic [31:0] p);
`ifdef IFETCH_ALIGN_CHECK_EN
    return p;
`else
    return p & ~32'h3;
`endif
  endfunction

  localparam logic [31:0] PC_INIT = load_pc(RESET_PC);

`ifdef IFETCH_ALIGN_CHECK_EN
  // Only reachable straight out of reset with a misaligned RESET_PC; every
  // other entry into S_REQ is screened in the next-state logic.
  assign req_misaligned = (idx_q == 2'd0) && (pc_q[1:0] != 2'b00);
`else
  assign req_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= PC_INIT;
      idx_q   <= 2'd0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    instr_d = instr_q;

    case (state_q)
      S_REQ: begin
        state_d = req_misaligned ? S_FAULT : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          instr_d[8*idx_q +: 8] = mem_rdata;
          if (idx_q == 2'd3) begin
            state_d = S_HOLD;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          idx_d   = 2'd0;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_REQ;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Redirect overrides sequential advance. A transfer in the same cycle
    // still completes because instr_valid is derived from state_q. A byte
    // arriving alongside the redirect belongs to the old stream and is
    // dropped; only a still-outstanding response needs DRAIN.
    if (redirect_valid) begin
      pc_d    = load_pc(redirect_pc);
      idx_d   = 2'd0;
      instr_d = instr_q;
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !mem_rvalid)
        state_d = S_DRAIN;
      else
        state_d = S_REQ;
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    if (state_d == S_REQ && idx_d == 2'd0 && pc_d[1:0] != 2'b00)
      state_d = S_FAULT;
`endif
  end

  // A redirect seen in S_REQ cancels the request so that no response is left
  // outstanding when fetch restarts at the new target.
  assign mem_req     = (state_q == S_REQ) && !redirect_valid && !rst && !req_misaligned;
  assign mem_addr    = pc_q[ADDR_W-1:0] + ADDR_W'(idx_q);
  assign instr_valid = (state_q == S_HOLD);
  assign instr_out   = instr_q;
  assign pc_out      = pc_q;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign fault = (state_q == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage upstream of the nano-cpu execute core (proc).
- Reads a byte-wide instruction memory one byte per request, with variable latency and one request outstanding.
- Assembles each little-endian 32-bit RV32 instruction and hands it downstream over a valid/ready handshake.
- Accepts PC redirects from execute for taken branches and JAL.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- ADDR_W, 10, width of the memory byte address; the low ADDR_W bits of the fetch address are driven.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- mem_req  output  1  byte read request, exactly one cycle wide.
- mem_addr  output  ADDR_W  byte address; valid while mem_req is high.
- mem_rvalid  input  1  read data valid; exactly one response per request, at least 1 cycle after the request.
- mem_rdata  input  8  read byte.
- instr_valid  output  1  instr_out and pc_out hold a complete instruction.
- instr_ready  input  1  downstream accepts; transfer occurs when instr_valid && instr_ready.
- instr_out  output  32  assembled instruction, {b3,b2,b1,b0}.
- pc_out  output  32  address of instr_out.
- redirect_valid  input  1  load redirect_pc as the next fetch PC.
- redirect_pc  input  32  redirect target.
- fault  output  1  misaligned-PC fault (see Optional Feature).

Behaviour:
- Reset (sampled on posedge when rst=1): pc=RESET_PC, idx=0, state=REQ, pending-discard=0.
  - Outputs after reset: instr_valid=0, instr_out=0, pc_out=RESET_PC, mem_req=0, fault=0.
  - Reset mid-operation aborts everything. The memory shares rst, so no stale response arrives after reset.
- State REQ: mem_req=1 and mem_addr=(pc+idx)[ADDR_W-1:0] for one cycle, then WAIT.
- State WAIT: mem_req=0. On mem_rvalid, byte lane idx of the assembly register is set to mem_rdata.
  - If idx==3: go to HOLD and set instr_valid=1.
  - Otherwise: idx++ and go to REQ.
- State HOLD: instr_out and pc_out are stable and mem_req=0 until transfer.
  - On transfer: instr_valid=0 next cycle, pc=pc+4 (mod 2^32), idx=0, go to REQ.
- mem_rvalid outside WAIT/DRAIN is ignored.
- Latency with a 1-cycle memory: 2 cycles per byte.
  - First instr_valid is on the 8th posedge after rst deasserts.
  - Steady state: one instruction per 9 cycles with instr_ready held high (8 cycles fetch + 1 cycle transfer).
- Redirect has priority over sequential advance, in any state. Next cycle: pc=redirect_pc, idx=0, instr_valid=0.
  - From WAIT (response outstanding): go to DRAIN. Wait for mem_rvalid, discard the byte, then go to REQ. mem_req=0 in DRAIN.
  - From DRAIN: the new target overwrites pc; stay in DRAIN.
  - From REQ or HOLD: go to REQ.
  - Redirect in the same cycle as a transfer: the transfer completes (downstream owns the instruction), and the next pc is redirect_pc, not pc+4.
- Address arithmetic: pc+idx and pc+4 wrap modulo 2^32. mem_addr is the truncated low ADDR_W bits.
- instr_out retains its last value when instr_valid=0. Its contents are don't-care when invalid.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - Entering REQ with idx==0 and pc[1:0]!=0 goes to FAULT instead.
  - In FAULT: fault=1, instr_valid=0, mem_req=0.
  - FAULT exits only on redirect (to REQ, re-checked) or reset. fault drops the cycle after leaving FAULT.
- Undefined:
  - pc[1:0] is forced to 0 whenever pc is loaded (reset, redirect).
  - Fetch and pc_out use the word-aligned address.
  - fault is tied 0.

Test Plan:
- Reset with RESET_PC=0, 1-cycle memory, bytes 0..3 = 13 05 50 00, instr_ready=1:
  - mem_addr sequence 0,1,2,3, one request every 2 cycles.
  - instr_valid on the 8th posedge, instr_out=32'h00500513, pc_out=0.
  - Next mem_req at address 4.
- Backpressure: instr_ready=0 for 5 cycles in HOLD:
  - instr_valid stays 1, instr_out and pc_out unchanged, no mem_req.
  - On ready=1: one transfer, then a request to pc+4.
- Redirect to 0x100 coincident with a transfer of pc 0x8:
  - Transfer counted.
  - Next mem_addr=0x100, next pc_out=0x100, no fetch from 0xC.
- Memory latency 3, redirect to 0x200 while waiting on byte 2 of pc 0x40:
  - No mem_req until the outstanding rvalid arrives; that byte is discarded.
  - Fetch restarts at 0x200..0x203, and instr_out contains only those bytes.
- RESET_PC=32'hFFFFFFFC, ADDR_W=10:
  - mem_addr 0x3FC..0x3FF, pc_out=32'hFFFFFFFC.
  - After transfer, next pc_out=0 and mem_addr=0.
- IFETCH_ALIGN_CHECK_EN defined, redirect to 0x102:
  - fault=1, no mem_req for 10 cycles.
  - Redirect to 0x104: fault=0, fetch at 0x104.
- IFETCH_ALIGN_CHECK_EN undefined, same stimulus: fetch at 0x100, pc_out=0x100, fault=0.
